// File: rtl/minisys_mem_pkg.sv
// Shared encodings for the MEM-stage access controller: load/store width codes,
// controller FSM states, default IO window base and the alignment helper.
package minisys_mem_pkg;

  localparam logic [1:0]  W_BYTE          = 2'b00;
  localparam logic [1:0]  W_HALF          = 2'b01;
  localparam logic [1:0]  W_WORD          = 2'b10;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam int          TCNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  // Width code 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      W_BYTE:  return 1'b0;
      W_HALF:  return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data lane replication and
// load-data extraction with sign/zero extension.
module mem_lane_align
  import minisys_mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  function automatic logic [31:0] extend_byte(input logic [7:0] v, input logic s);
    logic signed [7:0]  sv;
    logic signed [31:0] ext;
    sv  = v;
    ext = sv;
    return s ? ext : {24'b0, v};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] v, input logic s);
    logic signed [15:0] sv;
    logic signed [31:0] ext;
    sv  = v;
    ext = sv;
    return s ? ext : {16'b0, v};
  endfunction

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    load_data = rdata;
    case (width)
      W_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = extend_byte(8'(rdata >> {addr_lo, 3'b000}), sign);
      end
      W_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_data = extend_half(16'(rdata >> {addr_lo[1], 4'b0000}), sign);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory/IO access controller: one bus transaction per access, pipeline
// stall until completion, timeout error. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_access_ctrl
  import minisys_mem_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        mem_sign,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_bus_err,
  output logic        mem_misalign
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

  mem_state_t        state, state_next;
  logic [TCNT_W-1:0] tcnt;
  logic [1:0]        width_q, addr_lo_q;
  logic              sign_q;
  logic              access, start, misalign_now;
  logic [1:0]        al_width, al_addr_lo;
  logic              al_sign;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata_rep, al_load;

  assign access = mem_valid & (mem_write | mem_read);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign_now = is_misaligned(mem_width, mem_addr[1:0]);
  assign mem_misalign = (state == ST_DONE) & misalign_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= (state == ST_IDLE) & access & misalign_now;
  end
`else
  assign misalign_now = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  assign start = (state == ST_IDLE) & access & ~misalign_now;

  // Lane logic sees live inputs while launching and the captured controls during REQ.
  always_comb begin
    if (state == ST_REQ) begin
      al_width   = width_q;
      al_addr_lo = addr_lo_q;
      al_sign    = sign_q;
    end else begin
      al_width   = mem_width;
      al_addr_lo = mem_addr[1:0];
      al_sign    = mem_sign;
    end
  end

  mem_lane_align u_lane_align (
    .width     (al_width),
    .addr_lo   (al_addr_lo),
    .sign      (al_sign),
    .wdata     (mem_wdata),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata_rep),
    .load_data (al_load)
  );

  always_comb begin
    state_next  = state;
    bus_req     = 1'b0;
    mem_done    = 1'b0;
    mem_bus_err = 1'b0;
    mem_stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_stall = access;
        if (access) state_next = misalign_now ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        bus_req   = 1'b1;
        mem_stall = 1'b1;
        if (bus_ack)                state_next = ST_DONE;
        else if (tcnt >= TCNT_LAST) state_next = ST_ERR;
      end
      ST_ERR: begin
        mem_bus_err = 1'b1;
        mem_stall   = 1'b1;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        mem_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      bus_we    <= 1'b0;
      bus_io    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      mem_rdata <= '0;
      width_q   <= W_BYTE;
      addr_lo_q <= 2'b00;
      sign_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        bus_we    <= mem_write;
        bus_io    <= mem_addr >= IO_BASE;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        bus_be    <= al_be;
        bus_wdata <= al_wdata_rep;
        width_q   <= mem_width;
        addr_lo_q <= mem_addr[1:0];
        sign_q    <= mem_sign;
        tcnt      <= '0;
      end else if (state == ST_REQ && !bus_ack && tcnt != TCNT_MAX) begin
        tcnt <= tcnt + 1'b1;
      end
      // Stores, timeouts and trapped accesses all hand a zero result to MEM/WB.
      if (state == ST_REQ && bus_ack)
        mem_rdata <= bus_we ? '0 : al_load;
      else if (state_next == ST_ERR || (state == ST_IDLE && access && misalign_now))
        mem_rdata <= '0;
    end
  end

endmodule
